// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS_AES MEM stage: access FSM states,
// write-back select encodings and the word-alignment helper.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_MEM  = 2'b01;
    localparam logic [1:0] MTR_UIMM = 2'b10;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write enable and destination
// but keeps the previous data so downstream forwarding sees a stable value.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        reg_write,
    input  logic [4:0]  dest,
    input  logic [31:0] data,
    output logic        wb_reg_write,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg_write <= 1'b0;
            wb_dest      <= 5'd0;
            wb_data      <= 32'd0;
        end else if (bubble) begin
            wb_reg_write <= 1'b0;
            wb_dest      <= 5'd0;
        end else begin
            wb_reg_write <= reg_write;
            wb_dest      <= dest;
            wb_data      <= data;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs word loads/stores over a req/ack bus, stalls upstream while an
// access is outstanding, selects the write-back value and feeds the MEM/WB register.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_MEM,
    input  logic [1:0]  MemtoReg_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] ALUData_MEM,
    input  logic [31:0] UpperImm_MEM,
    input  logic [31:0] MemWriteData_MEM,
    input  logic [4:0]  WBregister_MEM,
    input  logic        jal_MEM,
    input  logic [31:0] PC_8_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        RegWrite_WB,
    output logic [4:0]  WBregister_WB,
    output logic [31:0] WBData_WB,
    output state_t      fsm_state
);

    localparam int CNT_W = $clog2(TIMEOUT);

    // Bus handshake: dmem_req rises with the op and holds, with address/we/wdata
    // stable, until the cycle dmem_ack is seen; it is derived only from state and
    // EX/MEM inputs, never from dmem_ack.
    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, cnt_next;
    logic [31:0]      load_buf, buf_next;
    logic             err_next;
    logic             req;
    logic             mem_op;
    logic [31:0]      wb_sel;

    assign mem_op = MemRead_MEM | MemWrite_MEM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            load_buf <= 32'd0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
            load_buf <= buf_next;
            bus_err  <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = wait_cnt;
        buf_next   = load_buf;
        err_next   = bus_err;
        req        = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        state_next = DONE;
                        if (!MemWrite_MEM) buf_next = dmem_rdata;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = '0;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    state_next = DONE;
                    if (!MemWrite_MEM) buf_next = dmem_rdata;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    buf_next   = 32'd0;
                end else begin
                    cnt_next = wait_cnt + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dmem_req   = req;
    assign mem_stall  = req;
    assign dmem_we    = req & MemWrite_MEM;
    assign dmem_addr  = word_align(ALUData_MEM);
    assign dmem_wdata = MemWriteData_MEM;
    assign fsm_state  = state;

    always_comb begin
        wb_sel = ALUData_MEM;
        if (jal_MEM)                      wb_sel = PC_8_MEM;
        else if (MemtoReg_MEM == MTR_MEM)  wb_sel = load_buf;
        else if (MemtoReg_MEM == MTR_UIMM) wb_sel = UpperImm_MEM;
    end

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .bubble       (req),
        .reg_write    (RegWrite_MEM),
        .dest         (WBregister_MEM),
        .data         (wb_sel),
        .wb_reg_write (RegWrite_WB),
        .wb_dest      (WBregister_WB),
        .wb_data      (WBData_WB)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4; each task drives one
// scenario and checks outputs against hand-computed values.
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_MEM;
    logic [1:0]  MemtoReg_MEM;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [31:0] ALUData_MEM;
    logic [31:0] UpperImm_MEM;
    logic [31:0] MemWriteData_MEM;
    logic [4:0]  WBregister_MEM;
    logic        jal_MEM;
    logic [31:0] PC_8_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        bus_err;
    logic        RegWrite_WB;
    logic [4:0]  WBregister_WB;
    logic [31:0] WBData_WB;
    state_t      fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .RegWrite_MEM     (RegWrite_MEM),
        .MemtoReg_MEM     (MemtoReg_MEM),
        .MemRead_MEM      (MemRead_MEM),
        .MemWrite_MEM     (MemWrite_MEM),
        .ALUData_MEM      (ALUData_MEM),
        .UpperImm_MEM     (UpperImm_MEM),
        .MemWriteData_MEM (MemWriteData_MEM),
        .WBregister_MEM   (WBregister_MEM),
        .jal_MEM          (jal_MEM),
        .PC_8_MEM         (PC_8_MEM),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .mem_stall        (mem_stall),
        .bus_err          (bus_err),
        .RegWrite_WB      (RegWrite_WB),
        .WBregister_WB    (WBregister_WB),
        .WBData_WB        (WBData_WB),
        .fsm_state        (fsm_state)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        RegWrite_MEM     = 1'b0;
        MemtoReg_MEM     = MTR_ALU;
        MemRead_MEM      = 1'b0;
        MemWrite_MEM     = 1'b0;
        ALUData_MEM      = 32'd0;
        UpperImm_MEM     = 32'd0;
        MemWriteData_MEM = 32'd0;
        WBregister_MEM   = 5'd0;
        jal_MEM          = 1'b0;
        PC_8_MEM         = 32'd0;
        dmem_ack         = 1'b0;
        dmem_rdata       = 32'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", fsm_state, IDLE); end
        checks++; if ({RegWrite_WB, WBregister_WB, WBData_WB} !== 38'd0) begin errors++; $display("FAIL reset_wb got %0b %0d %h exp 0", RegWrite_WB, WBregister_WB, WBData_WB); end
        checks++; if ({bus_err, dmem_req, dmem_we, mem_stall} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {bus_err, dmem_req, dmem_we, mem_stall}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu;
        RegWrite_MEM = 1'b1; MemtoReg_MEM = MTR_ALU; ALUData_MEM = 32'h0000_1234; WBregister_MEM = 5'd5;
        #1;
        checks++; if ({mem_stall, dmem_req} !== 2'b00) begin errors++; $display("FAIL alu_nostall got %b exp 00", {mem_stall, dmem_req}); end
        step();
        checks++; if ({RegWrite_WB, WBregister_WB, WBData_WB} !== {1'b1, 5'd5, 32'h0000_1234}) begin errors++; $display("FAIL alu_wb got %0b %0d %h exp 1 5 00001234", RegWrite_WB, WBregister_WB, WBData_WB); end
        clear_inputs();
    endtask

    task automatic test_load_first_ack;
        RegWrite_MEM = 1'b1; MemtoReg_MEM = MTR_MEM; MemRead_MEM = 1'b1; ALUData_MEM = 32'h0000_0103;
        WBregister_MEM = 5'd8; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({dmem_req, dmem_we, mem_stall} !== 3'b101) begin errors++; $display("FAIL load_req got %b exp 101", {dmem_req, dmem_we, mem_stall}); end
        checks++; if (dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL load_addr got %h exp 00000100", dmem_addr); end
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #1;
        checks++; if ({fsm_state, mem_stall, dmem_req, RegWrite_WB} !== {DONE, 3'b000}) begin errors++; $display("FAIL load_done got %0d %b exp 2 000", fsm_state, {mem_stall, dmem_req, RegWrite_WB}); end
        step();
        clear_inputs();
        checks++; if ({RegWrite_WB, WBregister_WB, WBData_WB} !== {1'b1, 5'd8, 32'hDEAD_BEEF}) begin errors++; $display("FAIL load_wb got %0b %0d %h exp 1 8 deadbeef", RegWrite_WB, WBregister_WB, WBData_WB); end
        checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL load_idle got %0d exp 0", fsm_state); end
    endtask

    // Store with MemtoReg=01: the write-back must still show the earlier load word.
    task automatic test_store_wait;
        int stalls = 0;
        RegWrite_MEM = 1'b1; MemtoReg_MEM = MTR_MEM; MemWrite_MEM = 1'b1; ALUData_MEM = 32'h0000_0202;
        MemWriteData_MEM = 32'hCAFE_0001; WBregister_MEM = 5'd9; dmem_rdata = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            if (mem_stall) stalls++;
            checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 32'h0000_0200, 32'hCAFE_0001}) begin errors++; $display("FAIL store_bus_%0d got %b %h %h exp 11 00000200 cafe0001", i, {dmem_req, dmem_we}, dmem_addr, dmem_wdata); end
            step();
            checks++; if (RegWrite_WB !== 1'b0) begin errors++; $display("FAIL store_bubble_%0d got %0b exp 0", i, RegWrite_WB); end
        end
        dmem_ack = 1'b0;
        #1;
        checks++; if (stalls !== 4 || mem_stall !== 1'b0 || fsm_state !== DONE) begin errors++; $display("FAIL store_stalls got %0d %0b %0d exp 4 0 2", stalls, mem_stall, fsm_state); end
        step();
        clear_inputs();
        checks++; if ({RegWrite_WB, WBregister_WB, WBData_WB} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_wb got %0b %0d %h exp 1 9 deadbeef", RegWrite_WB, WBregister_WB, WBData_WB); end
    endtask

    task automatic test_wb_select;
        RegWrite_MEM = 1'b1; jal_MEM = 1'b1; PC_8_MEM = 32'h0040_0008; WBregister_MEM = 5'd31;
        MemtoReg_MEM = MTR_UIMM; ALUData_MEM = 32'h0000_0055; UpperImm_MEM = 32'hABCD_0000;
        step();
        checks++; if ({WBregister_WB, WBData_WB} !== {5'd31, 32'h0040_0008}) begin errors++; $display("FAIL jal_wb got %0d %h exp 31 00400008", WBregister_WB, WBData_WB); end
        jal_MEM = 1'b0; WBregister_MEM = 5'd3;
        step();
        checks++; if ({WBregister_WB, WBData_WB} !== {5'd3, 32'hABCD_0000}) begin errors++; $display("FAIL uimm_wb got %0d %h exp 3 abcd0000", WBregister_WB, WBData_WB); end
        MemtoReg_MEM = 2'b11;
        step();
        checks++; if (WBData_WB !== 32'h0000_0055) begin errors++; $display("FAIL mtr11_wb got %h exp 00000055", WBData_WB); end
        clear_inputs();
    endtask

    task automatic test_timeout;
        int stalls = 0;
        RegWrite_MEM = 1'b1; MemtoReg_MEM = MTR_MEM; MemRead_MEM = 1'b1; ALUData_MEM = 32'h0000_0300;
        WBregister_MEM = 5'd7; dmem_rdata = 32'h7777_7777;
        #1;
        while (mem_stall && stalls < 20) begin
            stalls++;
            step();
        end
        checks++; if (stalls !== 5) begin errors++; $display("FAIL timeout_stalls got %0d exp 5", stalls); end
        checks++; if ({bus_err, fsm_state} !== {1'b1, DONE}) begin errors++; $display("FAIL timeout_err got %0b %0d exp 1 2", bus_err, fsm_state); end
        step();
        clear_inputs();
        checks++; if ({RegWrite_WB, WBregister_WB, WBData_WB} !== {1'b1, 5'd7, 32'h0}) begin errors++; $display("FAIL timeout_wb got %0b %0d %h exp 1 7 0", RegWrite_WB, WBregister_WB, WBData_WB); end
        step();
        step();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", bus_err); end
    endtask

    task automatic test_reset_mid_wait;
        RegWrite_MEM = 1'b1; MemtoReg_MEM = MTR_MEM; MemRead_MEM = 1'b1; ALUData_MEM = 32'h0000_0400; WBregister_MEM = 5'd4;
        step();
        step();
        checks++; if (fsm_state !== WAIT) begin errors++; $display("FAIL mid_wait got %0d exp 1", fsm_state); end
        rst = 1'b1;
        clear_inputs();
        step();
        checks++; if ({fsm_state, bus_err, RegWrite_WB, WBregister_WB, WBData_WB} !== {IDLE, 39'd0}) begin errors++; $display("FAIL mid_rst got %0d %0b %0b %0d %h exp 0 0 0 0 0", fsm_state, bus_err, RegWrite_WB, WBregister_WB, WBData_WB); end
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        #1;
        checks++; if ({dmem_req, mem_stall} !== 2'b00) begin errors++; $display("FAIL stray_ack_req got %b exp 00", {dmem_req, mem_stall}); end
        step();
        dmem_ack = 1'b0;
        checks++; if ({fsm_state, RegWrite_WB, WBData_WB} !== {IDLE, 33'd0}) begin errors++; $display("FAIL stray_ack got %0d %0b %h exp 0 0 0", fsm_state, RegWrite_WB, WBData_WB); end
        MemtoReg_MEM = MTR_MEM; RegWrite_MEM = 1'b1;
        step();
        checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL stray_ack_buf got %h exp 0", WBData_WB); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_first_ack();
        test_store_wait();
        test_wb_select();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
